// File: rtl/rifl_tx_gbn_controller.sv
// rifl_tx_gbn_controller: TX framing with go-back-N replay.
// Frames user beats, keeps a circular copy of every data frame and replays on request.

module rifl_tx_gbn_controller #(
    parameter int FRAME_WIDTH    = 256,
    parameter int PAYLOAD_WIDTH  = 240,
    parameter int FRAME_ID_WIDTH = 8,
    parameter int INTERLEAVE     = 1,
    parameter int MAX_RETRY      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_up,
    input  logic                      rx_error,
    input  logic                      pause_req,
    input  logic                      retrans_req,
    input  logic [FRAME_ID_WIDTH-1:0] retrans_id,
    input  logic                      compensate,
    input  logic [PAYLOAD_WIDTH+1:0]  rifl_tx_payload,
    output logic                      rifl_tx_ready,
    output logic [FRAME_WIDTH-1:0]    rifl_tx_data,
    output logic [2:0]                state,
    output logic [FRAME_ID_WIDTH-1:0] wr_id,
    output logic [7:0]                retry_cnt,
    output logic                      link_fail
);

    localparam int BW    = PAYLOAD_WIDTH + 2;
    localparam int HW    = PAYLOAD_WIDTH + 4;
    localparam int PADW  = FRAME_WIDTH - HW;
    localparam int CTLZ  = FRAME_WIDTH - 18;
    localparam int IDW   = FRAME_ID_WIDTH;
    localparam int DEPTH = 1 << IDW;

    localparam logic [15:0] KEY_IDLE    = 16'h0001;
    localparam logic [15:0] KEY_PAUSE   = 16'h0010;
    localparam logic [15:0] KEY_RETRANS = 16'h1000;

    localparam logic [2:0] ST_INIT         = 3'd0;
    localparam logic [2:0] ST_SEND_PAUSE   = 3'd1;
    localparam logic [2:0] ST_PAUSE        = 3'd2;
    localparam logic [2:0] ST_RETRANS      = 3'd3;
    localparam logic [2:0] ST_SEND_RETRANS = 3'd4;
    localparam logic [2:0] ST_NORMAL       = 3'd5;

    localparam logic [4:0] CLEAN_MIN = 5'd16;

    function automatic logic [FRAME_WIDTH-1:0] data_frame(
        input logic [BW-1:0] body
    );
        return FRAME_WIDTH'({2'b01, body}) << PADW;
    endfunction

    function automatic logic [FRAME_WIDTH-1:0] ctrl_frame(
        input logic [15:0] key
    );
        return FRAME_WIDTH'({2'b10, key}) << CTLZ;
    endfunction

    // replay buffer, indexed by frame ID
    logic [BW-1:0]          r_buf [DEPTH];

    logic [IDW:0]           r_init_cnt;
    logic [IDW-1:0]         r_wr_id;
    logic [IDW-1:0]         r_rd_id;
    logic [IDW:0]           r_rem;
    logic                   r_odd;
    logic                   r_active;
    logic                   r_req_d;
    logic [4:0]             r_clean;
    logic [IDW-1:0]         r_win;
    logic [7:0]             r_retry;
    logic                   r_fail;
    logic [FRAME_WIDTH-1:0] r_data;

    logic                   w_init_done;
    logic                   w_rise;
    logic [IDW-1:0]         w_diff;
    logic [IDW:0]           w_rem0;
    logic [IDW-1:0]         w_rd_cur;
    logic [IDW:0]           w_rem_cur;
    logic                   w_odd_cur;
    logic                   w_tail;
    logic                   w_replay;
    logic [2:0]             w_state;
    logic                   w_ctrl_slot;
    logic                   w_data_slot;
    logic                   w_in_rt;
    logic                   w_in_norm;
    logic                   w_norm_wr;
    logic                   w_ready;
    logic [1:0]             w_type;
    logic [BW-1:0]          w_body;
    logic                   w_win_full;
    logic                   w_mem_we;
    logic [IDW-1:0]         w_mem_addr;
    logic [BW-1:0]          w_mem_data;
    logic [FRAME_WIDTH-1:0] w_next;

    assign w_init_done = r_init_cnt[IDW];

    // a replay request only counts once the link is initialised and up
    assign w_rise = retrans_req & ~r_req_d & w_init_done & rx_up;

    // distance back to the requested ID; zero means the full ring
    assign w_diff = r_wr_id - retrans_id;
    assign w_rem0 = (w_diff == '0) ? (IDW+1)'(DEPTH) : {1'b0, w_diff};

    // a fresh request takes effect in the same cycle it is seen
    assign w_rd_cur  = w_rise ? retrans_id : r_rd_id;
    assign w_rem_cur = w_rise ? w_rem0 : r_rem;
    assign w_odd_cur = w_rise ? 1'b0 : r_odd;
    assign w_tail    = (w_rem_cur == '0);

    // replay stays active through the tail until the remote drops the request
    assign w_replay = w_rise | (r_active & ~(w_tail & ~retrans_req));

    // state priority: link down > remote pause > replay > local error > normal
    always_comb begin
        w_state = ST_NORMAL;
        if (!w_init_done) begin
            w_state = ST_INIT;
        end else if (!rx_up) begin
            w_state = ST_SEND_PAUSE;
        end else if (pause_req) begin
            w_state = ST_PAUSE;
        end else if (w_replay) begin
            w_state = ST_RETRANS;
        end else if (rx_error) begin
            w_state = ST_SEND_RETRANS;
        end
    end

    assign w_in_rt     = (w_state == ST_RETRANS);
    assign w_in_norm   = (w_state == ST_NORMAL);
    assign w_ctrl_slot = (INTERLEAVE != 0) && w_odd_cur;
    assign w_data_slot = w_in_rt & ~w_tail & ~w_ctrl_slot;

    assign w_norm_wr = w_in_norm & ~compensate;
    assign w_ready   = w_norm_wr & ~r_fail & (r_clean >= CLEAN_MIN);
    assign w_type    = rifl_tx_payload[BW-1 -: 2];
    assign w_body    = (w_ready && w_type != 2'b00) ? rifl_tx_payload : '0;

    assign w_win_full = (r_win == IDW'(DEPTH - 1));

    // INIT scrubs the ring; NORMAL stores whatever frame it sends
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = r_wr_id;
        w_mem_data = w_body;
        if (!w_init_done) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_init_cnt[IDW-1:0];
            w_mem_data = '0;
        end else if (w_norm_wr) begin
            w_mem_we = 1'b1;
        end
    end

    // next outgoing frame for the current state
    always_comb begin
        w_next = ctrl_frame(KEY_IDLE);
        unique case (w_state)
            ST_INIT: begin
                w_next = data_frame('0);
            end
            ST_SEND_PAUSE: begin
                w_next = ctrl_frame(KEY_PAUSE);
            end
            ST_PAUSE: begin
                w_next = ctrl_frame(KEY_IDLE);
            end
            ST_SEND_RETRANS: begin
                w_next = ctrl_frame(KEY_RETRANS);
            end
            ST_RETRANS: begin
                if (w_data_slot) begin
                    w_next = data_frame(r_buf[w_rd_cur]);
                end else if (!w_tail && rx_error) begin
                    w_next = ctrl_frame(KEY_RETRANS);
                end else begin
                    w_next = ctrl_frame(KEY_IDLE);
                end
            end
            ST_NORMAL: begin
                if (compensate) begin
                    w_next = ctrl_frame(KEY_IDLE);
                end else begin
                    w_next = data_frame(w_body);
                end
            end
            default: begin
                w_next = ctrl_frame(KEY_IDLE);
            end
        endcase
    end

    // ring storage, no reset: contents are rebuilt by INIT
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_buf[w_mem_addr] <= w_mem_data;
        end
    end

    // INIT walks every ring entry once after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_cnt <= '0;
        end else if (!w_init_done) begin
            r_init_cnt <= r_init_cnt + 1'b1;
        end
    end

    // write pointer advances on every stored data frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_id <= '0;
        end else if (w_norm_wr) begin
            r_wr_id <= r_wr_id + 1'b1;
        end
    end

    // request edge detector
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_d <= 1'b0;
        end else begin
            r_req_d <= retrans_req;
        end
    end

    // replay cursor; a pause holds it, link loss abandons it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_rd_id  <= '0;
            r_rem    <= '0;
            r_odd    <= 1'b0;
        end else if (!w_init_done || !rx_up) begin
            r_active <= 1'b0;
            r_rem    <= '0;
            r_odd    <= 1'b0;
        end else begin
            r_active <= w_replay;
            r_rd_id  <= w_rd_cur;
            r_rem    <= w_rem_cur;
            r_odd    <= w_odd_cur;
            if (w_in_rt && !w_tail) begin
                if (w_ctrl_slot) begin
                    r_odd <= 1'b0;
                end else begin
                    r_rd_id <= w_rd_cur + 1'b1;
                    r_rem   <= w_rem_cur - 1'b1;
                    r_odd   <= (INTERLEAVE != 0);
                end
            end
        end
    end

    // user traffic waits for 16 calm cycles after any replay
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clean <= '0;
        end else if (w_in_rt) begin
            r_clean <= '0;
        end else if (w_in_norm && r_clean < CLEAN_MIN) begin
            r_clean <= r_clean + 1'b1;
        end
    end

    // clean-window counter that forgives past replays
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= '0;
        end else if (!w_in_norm) begin
            r_win <= '0;
        end else if (!compensate) begin
            r_win <= w_win_full ? '0 : r_win + 1'b1;
        end
    end

    // retry accounting and the sticky failure flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retry <= '0;
            r_fail  <= 1'b0;
        end else begin
            if (w_rise) begin
                if (r_retry != 8'hFF) begin
                    r_retry <= r_retry + 1'b1;
                end
            end else if (w_norm_wr && w_win_full) begin
                r_retry <= '0;
            end
            if (MAX_RETRY != 0 && r_retry == 8'(MAX_RETRY)) begin
                r_fail <= 1'b1;
            end
        end
    end

    // registered frame output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= ctrl_frame(KEY_PAUSE);
        end else begin
            r_data <= w_next;
        end
    end

    assign rifl_tx_ready = w_ready;
    assign rifl_tx_data  = r_data;
    assign state         = w_state;
    assign wr_id         = r_wr_id;
    assign retry_cnt     = r_retry;
    assign link_fail     = r_fail;

endmodule

// File: tb/tb_rifl_tx_gbn_controller.sv
// tb_rifl_tx_gbn_controller: scoreboard bench for the go-back-N TX controller.
// Stimulus queues expected frames; a negedge monitor pops and compares them.

module tb_rifl_tx_gbn_controller;

    localparam int FW  = 256;
    localparam int PW  = 240;
    localparam int IDW = 4;

    typedef struct {
        int              due;
        logic [FW-1:0]   f;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            rx_up;
    logic            rx_error;
    logic            pause_req;
    logic            retrans_req;
    logic [IDW-1:0]  retrans_id;
    logic            compensate;
    logic [PW+1:0]   rifl_tx_payload;
    logic            rifl_tx_ready;
    logic [FW-1:0]   rifl_tx_data;
    logic [2:0]      state;
    logic [IDW-1:0]  wr_id;
    logic [7:0]      retry_cnt;
    logic            link_fail;

    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    exp_t            q[$];
    logic [PW+1:0]   mbuf [16];
    logic [IDW-1:0]  mw;

    rifl_tx_gbn_controller #(
        .FRAME_WIDTH(FW),
        .PAYLOAD_WIDTH(PW),
        .FRAME_ID_WIDTH(IDW),
        .INTERLEAVE(1),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_up(rx_up),
        .rx_error(rx_error),
        .pause_req(pause_req),
        .retrans_req(retrans_req),
        .retrans_id(retrans_id),
        .compensate(compensate),
        .rifl_tx_payload(rifl_tx_payload),
        .rifl_tx_ready(rifl_tx_ready),
        .rifl_tx_data(rifl_tx_data),
        .state(state),
        .wr_id(wr_id),
        .retry_cnt(retry_cnt),
        .link_fail(link_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [FW-1:0] dframe(input logic [PW+1:0] b);
        return {2'b01, b, 12'h000};
    endfunction

    function automatic logic [FW-1:0] cframe(input logic [15:0] k);
        return {2'b10, k, 238'd0};
    endfunction

    task automatic chk(input string n, input logic [FW-1:0] a,
                       input logic [FW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    task automatic chki(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got %0d want %0d", n, a, e);
        end
    endtask

    // monitor: frame for a cycle appears after the following edge
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("frame", rifl_tx_data, e.f);
        end
    end

    task automatic tick(input logic [FW-1:0] e);
        q.push_back('{due: cyc + 1, f: e});
        @(posedge clk);
        #1;
    endtask

    task automatic normal(input logic [1:0] t, input int v, input logic er);
        logic [PW+1:0] b;
        rifl_tx_payload = {t, 240'(v)};
        compensate = 1'b0;
        #1;
        chki("ready", int'(rifl_tx_ready), int'(er));
        b = (er && t != 2'b00) ? {t, 240'(v)} : '0;
        mbuf[mw] = b;
        mw = mw + 1'b1;
        tick(dframe(b));
    endtask

    task automatic replay(input logic [IDW-1:0] id, input logic rxe,
                          input int tail);
        logic [IDW-1:0] rd;
        logic [IDW-1:0] d;
        int             rem;
        retrans_req = 1'b1;
        retrans_id = id;
        rx_error = rxe;
        rifl_tx_payload = '0;
        d = mw - id;
        rem = (d == 0) ? 16 : int'(d);
        rd = id;
        #1;
        chki("state_rt", int'(state), 3);
        while (rem > 0) begin
            tick(dframe(mbuf[rd]));
            rd = rd + 1'b1;
            rem--;
            if (rem > 0) tick(rxe ? cframe(16'h1000) : cframe(16'h0001));
        end
        repeat (tail) tick(cframe(16'h0001));
        retrans_req = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic do_init();
        for (int i = 0; i < 16; i++) begin
            mbuf[i] = '0;
            #1;
            if (i == 0) chki("state_init", int'(state), 0);
            tick(dframe('0));
        end
        mw = '0;
    endtask

    initial begin
        rst = 1'b1;
        rx_up = 1'b1;
        rx_error = 1'b0;
        pause_req = 1'b0;
        retrans_req = 1'b0;
        retrans_id = '0;
        compensate = 1'b0;
        rifl_tx_payload = '0;
        mw = '0;
        @(posedge clk);
        #1;
        tick(cframe(16'h0010));
        tick(cframe(16'h0010));
        chki("rst_wr_id", int'(wr_id), 0);
        chki("rst_retry", int'(retry_cnt), 0);
        chki("rst_fail", int'(link_fail), 0);
        chki("rst_ready", int'(rifl_tx_ready), 0);
        rst = 1'b0;
        do_init();
        #1;
        chki("state_normal", int'(state), 5);
        for (int i = 0; i < 16; i++) normal(2'b00, 0, 1'b0);
        chki("wr_id_wrap", int'(wr_id), 0);

        for (int k = 1; k <= 5; k++) normal(2'b01, k, 1'b1);
        chki("wr_id_5", int'(wr_id), 5);
        rifl_tx_payload = {2'b01, 240'h6};
        compensate = 1'b1;
        #1;
        chki("comp_ready", int'(rifl_tx_ready), 0);
        tick(cframe(16'h0001));
        compensate = 1'b0;
        chki("comp_wr_id", int'(wr_id), 5);

        replay(4'd2, 1'b0, 2);
        chki("retry_1", int'(retry_cnt), 1);
        for (int i = 0; i < 16; i++) normal(2'b01, 16'h77, 1'b0);
        chki("retry_clear", int'(retry_cnt), 0);
        for (int i = 0; i < 16; i++) normal(2'b01, 16'h100 + i, 1'b1);
        chki("wr_id_full", int'(wr_id), 5);

        replay(4'd5, 1'b1, 1);
        chki("retry_2a", int'(retry_cnt), 1);
        for (int i = 0; i < 3; i++) normal(2'b00, 0, 1'b0);
        replay(4'd7, 1'b0, 1);
        chki("retry_2", int'(retry_cnt), 2);
        chki("link_fail", int'(link_fail), 1);
        for (int i = 0; i < 20; i++) normal(2'b01, 16'h200 + i, 1'b0);
        chki("fail_sticky", int'(link_fail), 1);

        retrans_req = 1'b1;
        retrans_id = 4'd8;
        #1;
        chki("state_rt4", int'(state), 3);
        tick(dframe(mbuf[8]));
        tick(cframe(16'h0001));
        rx_up = 1'b0;
        #1;
        chki("state_pause", int'(state), 1);
        tick(cframe(16'h0010));
        tick(cframe(16'h0010));
        rx_up = 1'b1;
        #1;
        chki("abort_state", int'(state), 5);
        normal(2'b00, 0, 1'b0);
        retrans_req = 1'b0;
        normal(2'b00, 0, 1'b0);

        rst = 1'b1;
        tick(cframe(16'h0010));
        rst = 1'b0;
        chki("rst2_wr_id", int'(wr_id), 0);
        chki("rst2_fail", int'(link_fail), 0);
        chki("rst2_retry", int'(retry_cnt), 0);
        do_init();
        #1;
        chki("state_normal2", int'(state), 5);
        for (int i = 0; i < 3; i++) normal(2'b01, 9, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        chki("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
